// File: rtl/rsa_pkg.sv
// Shared RSA definitions for the tag-side encryption and reader-side decryption paths.
package rsa_pkg;

  localparam int WORD_SIZE = 8;

  typedef enum logic [2:0] {
    IDLE,
    LOAD,
    MULT,
    UPDATE,
    DONE
  } state_t;

  localparam logic [WORD_SIZE-1:0] RESULT_INIT = WORD_SIZE'(1);

endpackage

// File: rtl/mod_mul_serial.sv
// Serial modular multiplier: p = a*b mod n, MSB-first interleaved shift-add-reduce in WordSize cycles.
module mod_mul_serial #(
  parameter int WordSize = rsa_pkg::WORD_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [WordSize-1:0] a,
  input  logic [WordSize-1:0] b,
  input  logic [WordSize-1:0] n,
  output logic [WordSize-1:0] p,
  output logic                done
);

  localparam int CW = $clog2(WordSize + 1);

  logic [WordSize:0]   acc;
  logic [WordSize-1:0] a_q, b_q, n_q;
  logic [CW-1:0]       cnt;
  logic                running;

  // acc and a are always below n, so every intermediate stays below 2n.
  function automatic logic [WordSize:0] step(input logic [WordSize:0] acc_in,
                                             input logic [WordSize-1:0] a_in,
                                             input logic bit_in,
                                             input logic [WordSize-1:0] n_in);
    logic [WordSize:0] t;
    t = {acc_in[WordSize-1:0], 1'b0};
    if (t >= {1'b0, n_in}) t = t - {1'b0, n_in};
    if (bit_in) begin
      t = t + {1'b0, a_in};
      if (t >= {1'b0, n_in}) t = t - {1'b0, n_in};
    end
    return t;
  endfunction

  always_ff @(posedge clk) begin
    if (!reset) begin
      acc     <= '0;
      a_q     <= '0;
      b_q     <= '0;
      n_q     <= '0;
      cnt     <= '0;
      running <= 1'b0;
    end else if (start) begin
      a_q     <= a;
      n_q     <= n;
      b_q     <= {b[WordSize-2:0], 1'b0};
      acc     <= step('0, a, b[WordSize-1], n);
      cnt     <= CW'(WordSize - 1);
      running <= 1'b1;
    end else if (running) begin
      acc <= step(acc, a_q, b_q[WordSize-1], n_q);
      b_q <= {b_q[WordSize-2:0], 1'b0};
      cnt <= cnt - 1'b1;
      if (cnt == CW'(1)) running <= 1'b0;
    end
  end

  // done marks the cycle whose closing edge performs the final step; p is valid after it.
  assign done = running && (cnt == CW'(1));
  assign p    = acc[WordSize-1:0];

endmodule

// File: rtl/rsa_decrypt_rx.sv
// Reader-side RSA decryption: plaintext = cipher^d mod n, constant-time right-to-left square-and-multiply.
module rsa_decrypt_rx
  import rsa_pkg::*;
#(
  parameter int WordSize = WORD_SIZE
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [WordSize-1:0] cipher_in,
  input  logic                cipher_valid,
  output logic                cipher_ready,
  input  logic [WordSize-1:0] priv_key,
  input  logic [WordSize-1:0] mod,
  output logic [WordSize-1:0] plain_out,
  output logic                plain_valid,
  input  logic                plain_ready,
  output logic                busy,
  output logic                err
);

  localparam int KW = $clog2(WordSize);

  state_t              state;
  logic [WordSize-1:0] cipher_q, d_q, n_q;
  logic [WordSize-1:0] result, base;
  logic [KW-1:0]       k;
  logic                mul_start;
  logic [WordSize-1:0] p1, p2, upd_result;
  logic                done1, done2;

  mod_mul_serial #(.WordSize(WordSize)) u_mul_rb (
    .clk(clk), .reset(reset), .start(mul_start),
    .a(result), .b(base), .n(n_q), .p(p1), .done(done1)
  );

  mod_mul_serial #(.WordSize(WordSize)) u_mul_bb (
    .clk(clk), .reset(reset), .start(mul_start),
    .a(base), .b(base), .n(n_q), .p(p2), .done(done2)
  );

  // Both products are always computed; the key bit only selects which one is kept.
  assign upd_result = d_q[k] ? p1 : result;

  always_ff @(posedge clk) begin
    if (!reset) begin
      state        <= IDLE;
      cipher_ready <= 1'b1;
      plain_valid  <= 1'b0;
      plain_out    <= '0;
      err          <= 1'b0;
      busy         <= 1'b0;
      cipher_q     <= '0;
      d_q          <= '0;
      n_q          <= '0;
      result       <= '0;
      base         <= '0;
      k            <= '0;
      mul_start    <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (cipher_valid) begin
            cipher_q     <= cipher_in;
            d_q          <= priv_key;
            n_q          <= mod;
            cipher_ready <= 1'b0;
            busy         <= 1'b1;
            state        <= LOAD;
          end
        end
        LOAD: begin
          if (n_q < WordSize'(2) || cipher_q >= n_q) begin
            err       <= 1'b1;
            plain_out <= '0;
            state     <= DONE;
          end else begin
            result    <= WordSize'(RESULT_INIT);
            base      <= cipher_q;
            k         <= '0;
            mul_start <= 1'b1;
            state     <= MULT;
          end
        end
        MULT: begin
          mul_start <= 1'b0;
          if (done1 && done2) state <= UPDATE;
        end
        UPDATE: begin
          result <= upd_result;
          base   <= p2;
          k      <= k + 1'b1;
          if (k == KW'(WordSize - 1)) begin
            plain_out   <= upd_result;
            plain_valid <= 1'b1;
            state       <= DONE;
          end else begin
            mul_start <= 1'b1;
            state     <= MULT;
          end
        end
        DONE: begin
          // The error path arrives here with plain_valid still low and raises it one cycle later.
          if (!plain_valid) begin
            plain_valid <= 1'b1;
          end else if (plain_ready) begin
            plain_valid  <= 1'b0;
            plain_out    <= '0;
            err          <= 1'b0;
            busy         <= 1'b0;
            cipher_ready <= 1'b1;
            state        <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_rsa_decrypt_rx.sv
// Directed and model-driven checks for rsa_decrypt_rx (latency, errors, back-pressure, reset).
module tb_rsa_decrypt_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [7:0] cipher_in;
  logic       cipher_valid;
  logic       cipher_ready;
  logic [7:0] priv_key;
  logic [7:0] mod;
  logic [7:0] plain_out;
  logic       plain_valid;
  logic       plain_ready;
  logic       busy;
  logic       err;

  int pass_cnt = 0;
  int total_cnt = 0;

  rsa_decrypt_rx dut (
    .clk(clk), .reset(reset),
    .cipher_in(cipher_in), .cipher_valid(cipher_valid), .cipher_ready(cipher_ready),
    .priv_key(priv_key), .mod(mod),
    .plain_out(plain_out), .plain_valid(plain_valid), .plain_ready(plain_ready),
    .busy(busy), .err(err)
  );

  always #5 clk = ~clk;

  function automatic int modexp(int b, int e, int n);
    int r;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * b) % n;
    return r;
  endfunction

  function automatic int gcd(int a, int b);
    int t;
    while (b != 0) begin
      t = a % b;
      a = b;
      b = t;
    end
    return a;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic accept(input int c, input int d, input int n);
    cipher_in    = 8'(c);
    priv_key     = 8'(d);
    mod          = 8'(n);
    cipher_valid = 1'b1;
    tick();
    cipher_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = -1;
    for (int i = 1; i <= 300; i++) begin
      tick();
      if (plain_valid) begin
        cyc = i;
        break;
      end
    end
  endtask

  task automatic check(input string name, input int actual, input int expected);
    total_cnt++;
    if (actual !== expected)
      $display("FAIL %s: got %0d, required %0d", name, actual, expected);
    else
      pass_cnt++;
  endtask

  task automatic run_txn(input string name, input int c, input int d, input int n,
                         input int exp_plain, input int exp_err, input int exp_lat, input bit verbose);
    int cyc;
    accept(c, d, n);
    wait_valid(cyc);
    total_cnt++;
    if (cyc !== exp_lat) begin
      $display("FAIL %s latency: got %0d, required %0d", name, cyc, exp_lat);
      return;
    end
    pass_cnt++;
    total_cnt++;
    if (plain_out !== 8'(exp_plain)) $display("FAIL %s plain_out: got %0d, required %0d", name, plain_out, exp_plain);
    else pass_cnt++;
    total_cnt++;
    if (err !== 1'(exp_err)) $display("FAIL %s err: got %0b, required %0b", name, err, exp_err);
    else pass_cnt++;
    if (verbose) $display("txn %s c=%0d d=%0d n=%0d -> plain=%0d err=%0b lat=%0d", name, c, d, n, plain_out, err, cyc);
    tick();
    total_cnt++;
    if (plain_valid !== 1'b0 || cipher_ready !== 1'b1 || busy !== 1'b0)
      $display("FAIL %s handshake: got valid=%0b ready=%0b busy=%0b, required 0 1 0", name, plain_valid, cipher_ready, busy);
    else pass_cnt++;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    tick();
    tick();
    total_cnt++;
    if (cipher_ready !== 1'b1 || plain_valid !== 1'b0 || plain_out !== 8'd0 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset: got ready=%0b valid=%0b out=%0d err=%0b busy=%0b, required 1 0 0 0 0",
               cipher_ready, plain_valid, plain_out, err, busy);
    else pass_cnt++;
    reset = 1'b1;
    tick();
  endtask

  task automatic test_basic();
    run_txn("n33_d7_c31", 31, 7, 33, 4, 0, 73, 1'b1);
    run_txn("n143_d103_c128", 128, 103, 143, 2, 0, 73, 1'b1);
    run_txn("n143_c0", 0, 103, 143, 0, 0, 73, 1'b1);
    run_txn("n33_d0_c5", 5, 0, 33, 1, 0, 73, 1'b1);
    run_txn("n33_d255_c32", 32, 255, 33, 32, 0, 73, 1'b1);
  endtask

  task automatic test_error();
    run_txn("err_n1", 0, 7, 1, 0, 1, 2, 1'b1);
    run_txn("err_c40_n33", 40, 7, 33, 0, 1, 2, 1'b1);
    run_txn("err_c33_n33", 33, 7, 33, 0, 1, 2, 1'b1);
  endtask

  task automatic test_back_pressure();
    int cyc;
    int bad;
    plain_ready = 1'b0;
    accept(31, 7, 33);
    wait_valid(cyc);
    check("bp_latency", cyc, 73);
    // New requests while busy must be ignored.
    cipher_in    = 8'd2;
    priv_key     = 8'd3;
    mod          = 8'd143;
    cipher_valid = 1'b1;
    bad = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (plain_valid !== 1'b1 || plain_out !== 8'd4 || cipher_ready !== 1'b0 || busy !== 1'b1) bad++;
    end
    check("bp_hold_violations", bad, 0);
    cipher_valid = 1'b0;
    plain_ready  = 1'b1;
    tick();
    check("bp_release_valid", int'(plain_valid), 0);
    check("bp_release_ready", int'(cipher_ready), 1);
    tick();
    check("bp_no_reaccept", int'(cipher_ready), 1);
    $display("txn back_pressure held 20 cycles, released");
  endtask

  task automatic test_reset_mid();
    accept(31, 7, 33);
    // Accept edge, LOAD edge, then three full bits of 9 edges and 4 edges into bit 3's MULT.
    repeat (1 + 9 * 3 + 4) tick();
    check("mid_busy_before_reset", int'(busy), 1);
    reset = 1'b0;
    tick();
    total_cnt++;
    if (cipher_ready !== 1'b1 || plain_valid !== 1'b0 || plain_out !== 8'd0 || err !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset: got ready=%0b valid=%0b out=%0d err=%0b busy=%0b, required 1 0 0 0 0",
               cipher_ready, plain_valid, plain_out, err, busy);
    else pass_cnt++;
    reset = 1'b1;
    tick();
    $display("txn reset during MULT bit 3");
    run_txn("after_reset", 31, 7, 33, 4, 0, 73, 1'b1);
  endtask

  task automatic test_random();
    int primes[5] = '{3, 5, 7, 11, 13};
    int p, q, n, phi, e, d, m, c, i, j;
    int pass_before;
    pass_before = pass_cnt;
    for (int t = 0; t < 400; t++) begin
      i = $urandom_range(0, 4);
      do j = $urandom_range(0, 4); while (j == i);
      p = primes[i];
      q = primes[j];
      n = p * q;
      phi = (p - 1) * (q - 1);
      do e = $urandom_range(2, phi - 1); while (gcd(e, phi) != 1);
      d = 0;
      for (int x = 1; x < phi; x++) if ((e * x) % phi == 1) d = x;
      m = $urandom_range(0, n - 1);
      c = modexp(m, e, n);
      run_txn("random", c, d, n, m, 0, 73, 1'b1);
    end
    $display("txn random batch: %0d checks passed of 1600", pass_cnt - pass_before);
  endtask

  initial begin
    reset        = 1'b0;
    cipher_in    = '0;
    cipher_valid = 1'b0;
    priv_key     = '0;
    mod          = '0;
    plain_ready  = 1'b1;
    test_reset();
    test_basic();
    test_error();
    test_back_pressure();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule
